int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller between the peripheral interrupt lines (keyboard, switch, counter, disk, VRAM, RAM) and the multi-cycle CPU's `INT`/`Cause_in` inputs. It replaces the fixed OR/priority-mux glue in the top level. Each source has a synchronized rising-edge detector, a pending latch and a mask bit. The block presents the highest-priority pending, unmasked source as a registered interrupt request plus cause code. It is a Wishbone slave on the existing intercon, where software reads the pending, mask and cause registers, writes the mask register and clears pending bits.

## Interface
- `N_SRC`, 8: number of interrupt sources (1..16).
- `RESET_MASK`, {N_SRC{1'b1}}: mask register value after reset (1 = enabled).
- `clk`  in  1: system clock (CPU clock domain).
- `rst`  in  1: asynchronous, active-high reset.
- `irq`  in  N_SRC: raw source lines, asynchronous to `clk`, level high = asserted.
- `STB`  in  1: bus strobe from intercon.
- `WE`  in  1: 1 = write, 0 = read; sampled with `STB`.
- `ADDR`  in  32: byte address; only `ADDR[3:2]` decoded.
- `DAT_I`  in  32: write data.
- `DAT_O`  out  32: registered read data, valid while `ACK` = 1.
- `ACK`  out  1: bus acknowledge.
- `INT`  out  1: interrupt request to CPU.
- `CAUSE`  out  32: index of the selected source when `INT` = 1, else 0.

## Operation
- Synchronizer: per bit, `irq` goes through `s1` then `s2`, then `prev`; `rise = s2 & ~prev`.
- Pending: `pend[i]` is set on `rise[i]` and cleared by a CLEAR write with `DAT_I[i]` = 1. If set and clear hit the same bit in the same cycle, set wins.
- Selection: `act = pend & mask`. Priority goes to the lowest index, so bit 0 is highest.
- `INT` and `CAUSE` are registered from `act` each cycle: `INT <= |act` and `CAUSE <= index of lowest set bit` (0 if none).
- Register map, `ADDR[3:2]`:
  - 0 PENDING, RO: `{0, pend}`.
  - 1 MASK, RW: `{0, mask}`; a write takes `DAT_I[N_SRC-1:0]`.
  - 2 CLEAR, WO: write-1-to-clear `pend`; reads return 0.
  - 3 CAUSE, RO: `{INT, 0, CAUSE[4:0]}`, with bit 31 = request valid.
- Writes to RO registers are ignored. Bits above `N_SRC` read 0.
- Bus FSM:
  - IDLE: on `STB` = 1, perform the access (write commits on this edge; read data captured into `DAT_O`) and go to RESP.
  - RESP: `ACK` = 1 for exactly one cycle, then go to HOLD.
  - HOLD: wait for `STB` = 0, then go to IDLE. This prevents a held strobe from double-committing a write.

## Timing
- Reset values:
  - `pend` = 0, `mask` = `RESET_MASK`, `s1`/`s2`/`prev` = 0.
  - `INT` = 0, `CAUSE` = 0, `ACK` = 0, `DAT_O` = 0, FSM = IDLE.
- Reset mid-transaction aborts immediately: `ACK` drops and no write commits after `rst` asserts.
- Interrupt latency:
  - `irq[i]` high before edge E1 gives `s1` at E1, `s2` at E2 and `pend` set at E3.
  - `INT` and `CAUSE` update at E4.
  - An `irq` pulse must be high for at least 2 clocks to be guaranteed seen.
- Level held high produces one pending event only. The source must fall and rise again to re-pend.
- Bus timing:
  - `STB` seen at edge N: the write commits at N and `ACK` = 1 during cycle N..N+1.
  - Read data reflects state sampled at edge N.
  - Minimum transaction is 3 cycles including HOLD.
- Mask write or CLEAR at edge N: `INT`/`CAUSE` reflect the new `act` at edge N+1.
- Simultaneous rises on several sources all latch. `CAUSE` shows the lowest index; after it is cleared, the next lowest appears one edge after the clear.

## Test plan
- Reset, then read all four registers: PENDING = 0, MASK = 0x000000FF (N_SRC = 8), CLEAR = 0, CAUSE = 0. `INT` = 0.
- Pulse `irq[3]` for 2 clocks: `INT` rises exactly 4 edges after the pulse starts, `CAUSE` = 3, PENDING = 0x08. Write CLEAR = 0x08: `INT` = 0 one edge after commit.
- Raise `irq[5]` and `irq[3]` together: `CAUSE` = 3. Clear bit 3: `CAUSE` = 5 on the next edge, CAUSE reg = 0x80000005.
- Write MASK = 0xF7 with bit 3 pending: `INT` drops next edge and PENDING still = 0x08. Write MASK = 0xFF: `INT` returns, `CAUSE` = 3.
- Rise of `irq[2]` in the same cycle as a CLEAR of bit 2: `pend[2]` stays 1. Holding `STB` high for 6 cycles on a write gives one `ACK` pulse and one commit.
- Assert `rst` in RESP state during a MASK write: `ACK` = 0 immediately and MASK = 0xFF after reset.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: edge-latched, maskable interrupt controller with fixed
// lowest-index priority and a Wishbone slave register port.
module int_ctrl #(
  parameter int unsigned N_SRC = 8,
  parameter logic [N_SRC-1:0] RESET_MASK = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } state_t;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_MASK  = 2'd1;
  localparam logic [1:0] A_CLEAR = 2'd2;
  localparam logic [1:0] A_CAUSE = 2'd3;

  state_t state;

  logic [N_SRC-1:0] s1;
  logic [N_SRC-1:0] s2;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] clr;
  logic [4:0]       sel;
  logic [1:0]       reg_sel;
  logic             access;
  logic             wr_mask;
  logic             wr_clr;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign reg_sel = ADDR[3:2];
  assign access  = (state == IDLE) && STB;
  assign wr_mask = access && WE && (reg_sel == A_MASK);
  assign wr_clr  = access && WE && (reg_sel == A_CLEAR);
  assign clr     = wr_clr ? DAT_I[N_SRC-1:0] : '0;

  assign rise = s2 & ~prev;
  assign act  = pend & mask;

  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

  // Scan from the top so the lowest set index is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) sel = 5'(i);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      A_PEND:  rdata[N_SRC-1:0] = pend;
      A_MASK:  rdata[N_SRC-1:0] = mask;
      A_CLEAR: rdata = '0;
      A_CAUSE: rdata = {INT, 26'd0, CAUSE[4:0]};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= irq;
      s2   <= s1;
      prev <= s2;
    end
  end

  // A new edge in the same cycle as a clear must not be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      mask <= RESET_MASK;
    end else begin
      pend <= (pend & ~clr) | rise;
      if (wr_mask) mask <= DAT_I[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      INT   <= 1'b0;
      CAUSE <= '0;
    end else begin
      INT   <= |act;
      CAUSE <= {27'd0, sel};
    end
  end

  // HOLD waits out a lingering strobe so one access commits once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ACK   <= 1'b0;
      DAT_O <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ACK <= 1'b0;
          if (STB) begin
            state <= RESP;
            ACK   <= 1'b1;
            if (!WE) DAT_O <= rdata;
          end
        end
        RESP: begin
          ACK   <= 1'b0;
          state <= HOLD;
        end
        HOLD: begin
          ACK <= 1'b0;
          if (!STB) state <= IDLE;
        end
        default: begin
          ACK   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed plus randomized stimulus against an event-level
// reference model; expected bus responses go through a scoreboard queue.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        STB = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        INT;
  logic [31:0] CAUSE;

  int_ctrl #(.N_SRC(8), .RESET_MASK(8'hFF)) dut (
    .clk(clk), .rst(rst), .irq(irq),
    .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK(ACK), .INT(INT), .CAUSE(CAUSE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;

  // Bus request handed to the model: commits at the next clock edge.
  logic        req_go = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_a = '0;
  logic [31:0] req_d = '0;

  // Model state: source history, pending, mask and the visible outputs.
  logic [7:0]  m_pend = '0;
  logic [7:0]  m_mask = 8'hFF;
  logic [7:0]  m_act = '0;
  logic [7:0]  m_clr = '0;
  logic [7:0]  h1 = '0;
  logic [7:0]  h2 = '0;
  logic [7:0]  h3 = '0;
  logic        m_int = 1'b0;
  logic [31:0] m_cause = '0;
  logic        m_ack = 1'b0;
  logic [31:0] m_rd = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 32'(i);
    return 32'd0;
  endfunction

  // An edge on irq sampled at clock k-2 (low at k-3) pends at clock k;
  // INT/CAUSE follow the pending/mask state one clock later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_mask = 8'hFF; m_int = 1'b0; m_cause = '0;
      m_ack = 1'b0; h1 = '0; h2 = '0; h3 = '0; req_go = 1'b0;
      sbq.delete();
    end else begin
      m_act = m_pend & m_mask;
      m_clr = '0;
      m_ack = 1'b0;
      if (req_go) begin
        req_go = 1'b0;
        m_ack = 1'b1;
        if (!req_we) begin
          case (req_a)
            2'd0: m_rd = {24'd0, m_pend};
            2'd1: m_rd = {24'd0, m_mask};
            2'd2: m_rd = 32'd0;
            default: m_rd = {m_int, 26'd0, m_cause[4:0]};
          endcase
          sbq.push_back('{rd: 1'b1, data: m_rd});
        end else begin
          sbq.push_back('{rd: 1'b0, data: 32'd0});
          if (req_a == 2'd1) m_mask = req_d[7:0];
          if (req_a == 2'd2) m_clr = req_d[7:0];
        end
      end
      m_pend = (m_pend & ~m_clr) | (h2 & ~h3);
      h3 = h2; h2 = h1; h1 = irq;
      m_int = |m_act;
      m_cause = lowest(m_act);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("int", 32'(INT), 32'(m_int));
      chk("cause", CAUSE, m_cause);
      chk("ack", 32'(ACK), 32'(m_ack));
      if (ACK) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL ack_unexpected: got ACK=1 expected no response at %0t", $time);
        end else begin
          e = sbq.pop_front();
          if (e.rd) chk("rdata", DAT_O, e.data);
        end
      end
    end
  end

  task automatic start(input logic we, input logic [1:0] a,
                       input logic [31:0] d);
    logic [31:0] r;
    r = $urandom;
    STB = 1'b1;
    WE = we;
    ADDR = {r[31:4], a, r[1:0]};
    DAT_I = d;
    req_we = we; req_a = a; req_d = d;
    req_go = 1'b1;
  endtask

  task automatic bus(input logic we, input logic [1:0] a,
                     input logic [31:0] d, input int hold);
    int k;
    start(we, a, d);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ACK && k < 10);
    if (!ACK) chk("ack_wait", 32'(ACK), 32'd1);
    repeat (hold) begin @(posedge clk); #1; end
    STB = 1'b0;
    WE = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy, cool, wt, op;
    logic [31:0] r;
    idle(3);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(1);

    for (int a = 0; a < 4; a++) bus(1'b0, 2'(a), 32'd0, 0);

    irq = 8'h08; idle(2); irq = 8'h00;
    idle(4);
    bus(1'b0, 2'd0, 0, 0);
    bus(1'b1, 2'd2, 32'h08, 0);
    idle(2);

    irq = 8'h28; idle(2); irq = 8'h00;
    idle(4);
    bus(1'b0, 2'd3, 0, 0);
    bus(1'b1, 2'd2, 32'h08, 0);
    bus(1'b0, 2'd3, 0, 0);
    bus(1'b1, 2'd2, 32'h20, 0);

    irq = 8'h08; idle(2); irq = 8'h00;
    idle(4);
    bus(1'b1, 2'd1, 32'hF7, 0);
    bus(1'b0, 2'd0, 0, 0);
    bus(1'b1, 2'd1, 32'hFF, 0);
    idle(2);
    bus(1'b1, 2'd2, 32'h08, 0);

    irq[2] = 1'b1;
    idle(2);
    bus(1'b1, 2'd2, 32'h04, 0);
    bus(1'b0, 2'd0, 0, 0);
    irq[2] = 1'b0;
    bus(1'b1, 2'd2, 32'h04, 0);

    bus(1'b1, 2'd1, 32'h5A, 6);
    bus(1'b0, 2'd1, 0, 0);

    start(1'b1, 2'd1, 32'h00);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("ack_on_rst", 32'(ACK), 32'd0);
    STB = 1'b0; WE = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);
    bus(1'b0, 2'd1, 0, 0);

    busy = 0; cool = 0; wt = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      if (busy != 0) begin
        wt++;
        if (ACK || wt > 8) begin
          if (!ACK) chk("ack_wait", 32'(ACK), 32'd1);
          STB = 1'b0; WE = 1'b0;
          busy = 0; cool = 1;
        end
      end else if (cool > 0) begin
        cool--;
      end else if ($urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 4);
        r = $urandom;
        case (op)
          0, 1: start(1'b0, r[1:0], r);
          2: start(1'b1, 2'd1, r | 32'h0000_0099);
          3: start(1'b1, 2'd2, r);
          default: start(1'b1, r[0] ? 2'd3 : 2'd0, r);
        endcase
        busy = 1; wt = 0;
      end
    end
    STB = 1'b0; WE = 1'b0; irq = '0;
    idle(8);
    for (int a = 0; a < 4; a++) bus(1'b0, 2'(a), 32'd0, 0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
